// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: LC-3 memory / memory-mapped I/O access controller owning KBSR/KBDR/DSR/DDR
module mem_io_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR_OUT,
  input  logic [15:0] BUS_OUT,
  input  logic        MEM_READY,
  input  logic [15:0] MEM_RDATA,
  input  logic        KBD_STROBE,
  input  logic [7:0]  KBD_CHAR,
  input  logic        DISPLAY_ACK,
  output logic        R,
  output logic [1:0]  INMUX_SEL,
  output logic        MEM_EN,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic [15:0] MEM_OUT,
  output logic [15:0] KBDR_OUT,
  output logic [15:0] KBSR_OUT,
  output logic [15:0] DSR_OUT,
  output logic [7:0]  DDR_OUT,
  output logic        DISPLAY_VALID,
  output logic        KBD_INT,
  output logic        DSP_INT,
  output logic        KBD_OVERRUN,
  output logic        MEM_ERR
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, MEM_ACC, IO_ACC, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, mem_out_q, mem_out_d;
  logic [7:0] kbdr_q, kbdr_d, ddr_q, ddr_d;
  logic [1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rw_q, rw_d, kbsr15_q, kbsr15_d, kbsr14_q, kbsr14_d, dsr15_q, dsr15_d, dsr14_q, dsr14_d;
  logic dvalid_q, dvalid_d, ovr_q, ovr_d, err_q, err_d;
  logic kb_clr, timeout, io;
  // KBSR[15] clears at the edge ending a KBDR-read DONE, the same edge the MDR loads on
  assign kb_clr = state_q == DONE && !rw_q && addr_q == 16'hFE02;
  assign timeout = !MEM_READY && cnt_q == CW'(MEM_TIMEOUT - 1);
  assign io = MAR_OUT >= 16'hFE00;
  // next-state, access sequencing and device register updates
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rw_d = rw_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    mem_out_d = mem_out_q;
    kbdr_d = kbdr_q;
    kbsr15_d = kbsr15_q;
    kbsr14_d = kbsr14_q;
    dsr15_d = dsr15_q;
    dsr14_d = dsr14_q;
    ddr_d = ddr_q;
    dvalid_d = dvalid_q;
    ovr_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (MIO_EN) begin
        addr_d = MAR_OUT;
        wdata_d = BUS_OUT;
        rw_d = R_W;
        cnt_d = '0;
        state_d = io ? IO_ACC : MEM_ACC;
        sel_d = !io ? 2'b11 : MAR_OUT == 16'hFE00 ? 2'b01 : MAR_OUT == 16'hFE02 ? 2'b00 :
                MAR_OUT == 16'hFE04 ? 2'b10 : 2'b11;
      end
      MEM_ACC: begin
        cnt_d = cnt_q + CW'(1);
        if (MEM_READY) begin
          state_d = DONE;
          mem_out_d = rw_q ? mem_out_q : MEM_RDATA;
        end else if (timeout) begin
          state_d = DONE;
          err_d = 1'b1;
          mem_out_d = 16'h0000;
        end
      end
      IO_ACC: begin
        state_d = DONE;
        mem_out_d = sel_q == 2'b11 ? 16'h0000 : mem_out_q;
        if (rw_q && addr_q == 16'hFE00) kbsr14_d = wdata_q[14];
        if (rw_q && addr_q == 16'hFE04) dsr14_d = wdata_q[14];
        if (rw_q && addr_q == 16'hFE06 && dsr15_q) begin
          ddr_d = wdata_q[7:0];
          dsr15_d = 1'b0;
          dvalid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        kbsr15_d = kb_clr ? 1'b0 : kbsr15_q;
      end
      default: state_d = IDLE;
    endcase
    if (KBD_STROBE) begin
      if (!kbsr15_q || kb_clr) begin
        kbdr_d = KBD_CHAR;
        kbsr15_d = 1'b1;
      end else ovr_d = 1'b1;
    end
    if (DISPLAY_ACK && dvalid_q) begin
      dsr15_d = 1'b1;
      dvalid_d = 1'b0;
    end
  end
  // state and register file with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q <= 16'h0000;
      wdata_q <= 16'h0000;
      rw_q <= 1'b0;
      sel_q <= 2'b11;
      cnt_q <= '0;
      mem_out_q <= 16'h0000;
      kbdr_q <= 8'h00;
      kbsr15_q <= 1'b0;
      kbsr14_q <= 1'b0;
      dsr15_q <= 1'b1;
      dsr14_q <= 1'b0;
      ddr_q <= 8'h00;
      dvalid_q <= 1'b0;
      ovr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rw_q <= rw_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      mem_out_q <= mem_out_d;
      kbdr_q <= kbdr_d;
      kbsr15_q <= kbsr15_d;
      kbsr14_q <= kbsr14_d;
      dsr15_q <= dsr15_d;
      dsr14_q <= dsr14_d;
      ddr_q <= ddr_d;
      dvalid_q <= dvalid_d;
      ovr_q <= ovr_d;
      err_q <= err_d;
    end
  end
  assign R = state_q == DONE;
  assign MEM_EN = state_q == MEM_ACC;
  assign MEM_WE = state_q == MEM_ACC && rw_q;
  assign INMUX_SEL = sel_q;
  assign MEM_ADDR = addr_q;
  assign MEM_WDATA = wdata_q;
  assign MEM_OUT = mem_out_q;
  assign KBDR_OUT = {8'h00, kbdr_q};
  assign KBSR_OUT = {kbsr15_q, kbsr14_q, 14'h0000};
  assign DSR_OUT = {dsr15_q, dsr14_q, 14'h0000};
  assign DDR_OUT = ddr_q;
  assign DISPLAY_VALID = dvalid_q;
  assign KBD_INT = kbsr15_q & kbsr14_q;
  assign DSP_INT = dsr15_q & dsr14_q;
  assign KBD_OVERRUN = ovr_q;
  assign MEM_ERR = err_q;
endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb_mem_io_ctrl: directed table, corner sequences and random traffic against a transaction-level model
module tb_mem_io_ctrl;
  localparam int TO = 15;
  logic CLK = 1'b0, RESET, MIO_EN, R_W, MEM_READY, KBD_STROBE, DISPLAY_ACK;
  logic [15:0] MAR_OUT, BUS_OUT, MEM_RDATA;
  logic [7:0] KBD_CHAR;
  logic R, MEM_EN, MEM_WE, DISPLAY_VALID, KBD_INT, DSP_INT, KBD_OVERRUN, MEM_ERR;
  logic [1:0] INMUX_SEL;
  logic [15:0] MEM_ADDR, MEM_WDATA, MEM_OUT, KBDR_OUT, KBSR_OUT, DSR_OUT;
  logic [7:0] DDR_OUT;
  int total = 0, passed = 0;
  logic m_k15, m_k14, m_d15, m_d14, m_dv;
  logic [7:0] m_kbdr, m_ddr;
  logic [15:0] m_mo;
  logic [1:0] m_sel;
  typedef struct {
    logic [15:0] a; logic w; logic [15:0] d; int dly; logic [15:0] rd;
    int cyc; logic [1:0] sel; logic [15:0] mo; logic e;
  } vec_t;
  vec_t vecs [10];

  mem_io_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .MIO_EN(MIO_EN), .R_W(R_W), .MAR_OUT(MAR_OUT), .BUS_OUT(BUS_OUT),
    .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA), .KBD_STROBE(KBD_STROBE), .KBD_CHAR(KBD_CHAR),
    .DISPLAY_ACK(DISPLAY_ACK), .R(R), .INMUX_SEL(INMUX_SEL), .MEM_EN(MEM_EN), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_OUT(MEM_OUT), .KBDR_OUT(KBDR_OUT),
    .KBSR_OUT(KBSR_OUT), .DSR_OUT(DSR_OUT), .DDR_OUT(DDR_OUT), .DISPLAY_VALID(DISPLAY_VALID),
    .KBD_INT(KBD_INT), .DSP_INT(DSP_INT), .KBD_OVERRUN(KBD_OVERRUN), .MEM_ERR(MEM_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_k15 = 0; m_k14 = 0; m_d15 = 1; m_d14 = 0; m_dv = 0;
    m_kbdr = 8'h00; m_ddr = 8'h00; m_mo = 16'h0000; m_sel = 2'b11;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, " kbsr"}, 32'(KBSR_OUT), 32'({m_k15, m_k14, 14'h0}));
    chk({tag, " kbdr"}, 32'(KBDR_OUT), 32'({8'h00, m_kbdr}));
    chk({tag, " dsr"}, 32'(DSR_OUT), 32'({m_d15, m_d14, 14'h0}));
    chk({tag, " ddr"}, 32'(DDR_OUT), 32'(m_ddr));
    chk({tag, " dvalid"}, 32'(DISPLAY_VALID), 32'(m_dv));
    chk({tag, " kbd_int"}, 32'(KBD_INT), 32'(m_k15 & m_k14));
    chk({tag, " dsp_int"}, 32'(DSP_INT), 32'(m_d15 & m_d14));
    chk({tag, " sel"}, 32'(INMUX_SEL), 32'(m_sel));
    chk({tag, " mem_out"}, 32'(MEM_OUT), 32'(m_mo));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1;
    repeat (2) @(negedge CLK);
    RESET = 0;
    model_reset();
  endtask

  task automatic do_acc(input logic [15:0] a, input logic w, input logic [15:0] d, input int dly,
                        input logic [15:0] rd, output int cyc, output logic [1:0] sel,
                        output logic [15:0] mo, output logic err);
    logic io, eerr, kb_read;
    int ecyc;
    io = a >= 16'hFE00;
    kb_read = io && !w && a == 16'hFE02;
    @(negedge CLK);
    MAR_OUT = a; BUS_OUT = d; R_W = w; MIO_EN = 1;
    @(negedge CLK);
    MIO_EN = 0; MAR_OUT = 16'($urandom); BUS_OUT = 16'($urandom); R_W = 1'($urandom);
    cyc = 1;
    chk("mem_en", 32'(MEM_EN), 32'(!io));
    chk("mem_we", 32'(MEM_WE), 32'(!io && w));
    chk("mem_addr", 32'(MEM_ADDR), 32'(a));
    chk("mem_wdata", 32'(MEM_WDATA), 32'(d));
    while (!R && cyc < 40) begin
      MEM_READY = !io && cyc == dly + 1;
      MEM_RDATA = MEM_READY ? rd : 16'($urandom);
      @(negedge CLK);
      MEM_READY = 0;
      cyc++;
    end
    sel = INMUX_SEL; mo = MEM_OUT; err = MEM_ERR;
    ecyc = io ? 2 : (dly + 1 <= TO ? dly + 2 : TO + 1);
    eerr = !io && dly + 1 > TO;
    if (io) begin
      m_sel = a == 16'hFE00 ? 2'b01 : a == 16'hFE02 ? 2'b00 : a == 16'hFE04 ? 2'b10 : 2'b11;
      if (m_sel == 2'b11) m_mo = 16'h0000;
      if (w && a == 16'hFE00) m_k14 = d[14];
      if (w && a == 16'hFE04) m_d14 = d[14];
      if (w && a == 16'hFE06 && m_d15) begin
        m_ddr = d[7:0]; m_d15 = 0; m_dv = 1;
      end
    end else begin
      m_sel = 2'b11;
      if (eerr) m_mo = 16'h0000;
      else if (!w) m_mo = rd;
    end
    chk("r_cycle", 32'(cyc), 32'(ecyc));
    chk("mem_err", 32'(err), 32'(eerr));
    chk("done sel", 32'(sel), 32'(m_sel));
    chk("done mem_out", 32'(mo), 32'(m_mo));
    if (kb_read) begin
      chk("kbdr at done", 32'(KBDR_OUT), 32'({8'h00, m_kbdr}));
      m_k15 = 0;
    end
    @(negedge CLK);
    chk("r one cycle", 32'(R), 0);
    chk("err one cycle", 32'(MEM_ERR), 0);
    chk_regs("post");
  endtask

  task automatic strobe(input logic [7:0] ch);
    logic eo;
    @(negedge CLK);
    KBD_STROBE = 1; KBD_CHAR = ch;
    eo = m_k15;
    if (!m_k15) begin
      m_kbdr = ch; m_k15 = 1;
    end
    @(negedge CLK);
    KBD_STROBE = 0; KBD_CHAR = 8'($urandom);
    chk("overrun", 32'(KBD_OVERRUN), 32'(eo));
    chk_regs("strobe");
  endtask

  task automatic ack();
    @(negedge CLK);
    DISPLAY_ACK = 1;
    if (m_dv) begin
      m_d15 = 1; m_dv = 0;
    end
    @(negedge CLK);
    DISPLAY_ACK = 0;
    chk_regs("ack");
  endtask

  initial begin
    int c, dly;
    logic [1:0] s;
    logic [15:0] mo, a;
    logic e;
    RESET = 1; MIO_EN = 0; R_W = 0; MAR_OUT = 0; BUS_OUT = 0; MEM_READY = 0; MEM_RDATA = 0;
    KBD_STROBE = 0; KBD_CHAR = 0; DISPLAY_ACK = 0;
    vecs[0] = '{16'h3000, 1'b0, 16'h0000, 3, 16'h1234, 5, 2'b11, 16'h1234, 1'b0};
    vecs[1] = '{16'h3001, 1'b1, 16'hABCD, 0, 16'h5A5A, 2, 2'b11, 16'h1234, 1'b0};
    vecs[2] = '{16'hFE00, 1'b0, 16'h0000, 0, 16'h0000, 2, 2'b01, 16'h1234, 1'b0};
    vecs[3] = '{16'hFE04, 1'b0, 16'h0000, 0, 16'h0000, 2, 2'b10, 16'h1234, 1'b0};
    vecs[4] = '{16'h4000, 1'b0, 16'h0000, 14, 16'h5555, 16, 2'b11, 16'h5555, 1'b0};
    vecs[5] = '{16'h4000, 1'b0, 16'h0000, 20, 16'h9999, 16, 2'b11, 16'h0000, 1'b1};
    vecs[6] = '{16'h0000, 1'b0, 16'h0000, 0, 16'h7777, 2, 2'b11, 16'h7777, 1'b0};
    vecs[7] = '{16'hFE08, 1'b0, 16'h0000, 0, 16'h0000, 2, 2'b11, 16'h0000, 1'b0};
    vecs[8] = '{16'hFDFF, 1'b0, 16'h0000, 1, 16'h0BCD, 3, 2'b11, 16'h0BCD, 1'b0};
    vecs[9] = '{16'hFFFF, 1'b1, 16'h1234, 0, 16'h0000, 2, 2'b11, 16'h0000, 1'b0};
    do_reset();
    chk("reset r", 32'(R), 0);
    chk("reset mem_en", 32'(MEM_EN), 0);
    chk("reset mem_we", 32'(MEM_WE), 0);
    chk("reset mem_addr", 32'(MEM_ADDR), 0);
    chk("reset mem_wdata", 32'(MEM_WDATA), 0);
    chk("reset overrun", 32'(KBD_OVERRUN), 0);
    chk("reset mem_err", 32'(MEM_ERR), 0);
    chk("reset dsr", 32'(DSR_OUT), 32'h8000);
    chk("reset sel", 32'(INMUX_SEL), 3);
    chk_regs("reset");
    for (int i = 0; i < 10; i++) begin
      do_acc(vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].dly, vecs[i].rd, c, s, mo, e);
      chk($sformatf("vec%0d cycle", i), 32'(c), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d sel", i), 32'(s), 32'(vecs[i].sel));
      chk($sformatf("vec%0d mem_out", i), 32'(mo), 32'(vecs[i].mo));
      chk($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].e));
    end
    strobe(8'h41);
    chk("kbdr 41", 32'(KBDR_OUT), 32'h0041);
    strobe(8'h42);
    chk("kbdr kept 41", 32'(KBDR_OUT), 32'h0041);
    do_acc(16'hFE02, 1'b0, 16'h0000, 0, 16'h0000, c, s, mo, e);
    chk("kbsr cleared", 32'(KBSR_OUT), 0);
    do_acc(16'hFE06, 1'b1, 16'h0061, 0, 16'h0000, c, s, mo, e);
    chk("ddr 61", 32'(DDR_OUT), 32'h61);
    chk("dsr busy", 32'(DSR_OUT), 0);
    do_acc(16'hFE06, 1'b1, 16'h0062, 0, 16'h0000, c, s, mo, e);
    chk("ddr ignored", 32'(DDR_OUT), 32'h61);
    ack();
    chk("dsr ready", 32'(DSR_OUT), 32'h8000);
    ack();
    do_acc(16'hFE04, 1'b1, 16'h4000, 0, 16'h0000, c, s, mo, e);
    chk("dsp_int", 32'(DSP_INT), 1);
    strobe(8'h43);
    do_acc(16'hFE00, 1'b1, 16'h4000, 0, 16'h0000, c, s, mo, e);
    chk("kbd_int", 32'(KBD_INT), 1);
    @(negedge CLK);
    MAR_OUT = 16'hFE02; R_W = 0; MIO_EN = 1;
    @(negedge CLK);
    MIO_EN = 0;
    @(negedge CLK);
    chk("kbdr read done", 32'(R), 1);
    chk("old kbdr at done", 32'(KBDR_OUT), 32'h0043);
    KBD_STROBE = 1; KBD_CHAR = 8'h55;
    @(negedge CLK);
    KBD_STROBE = 0;
    m_kbdr = 8'h55; m_k15 = 1; m_sel = 2'b00;
    chk("no overrun at done", 32'(KBD_OVERRUN), 0);
    chk("kbdr 55", 32'(KBDR_OUT), 32'h0055);
    chk_regs("done strobe");
    @(negedge CLK);
    MAR_OUT = 16'h3000; BUS_OUT = 16'hBEEF; R_W = 1; MIO_EN = 1;
    @(negedge CLK);
    MIO_EN = 0;
    repeat (2) @(negedge CLK);
    chk("mid mem_en", 32'(MEM_EN), 1);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    model_reset();
    chk("abort mem_en", 32'(MEM_EN), 0);
    chk("abort r", 32'(R), 0);
    @(negedge CLK);
    chk("abort no r", 32'(R), 0);
    chk_regs("abort");
    do_acc(16'h3002, 1'b0, 16'h0000, 2, 16'h2468, c, s, mo, e);
    chk("after abort mem_out", 32'(mo), 32'h2468);
    for (int i = 0; i < 200; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 7) begin
        case ($urandom_range(0, 6))
          0: a = 16'hFE00;
          1: a = 16'hFE02;
          2: a = 16'hFE04;
          3: a = 16'hFE06;
          4: a = 16'hFE08;
          5: a = 16'($urandom_range(32'hFE0A, 32'hFFFF));
          default: a = 16'($urandom_range(0, 32'hFDFF));
        endcase
        dly = $urandom_range(0, 7) == 0 ? 16 : $urandom_range(0, 5);
        do_acc(a, 1'($urandom), 16'($urandom), dly, 16'($urandom), c, s, mo, e);
      end else if (op < 9) strobe(8'($urandom));
      else ack();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
